alu_seq_ctrl: RTL and testbench



---
 rtl/alu_seq_pkg.sv | 40 ++++
 rtl/alu_iter_cnt.sv | 26 ++
 rtl/alu_seq_ctrl.sv | 71 +++++++
 tb/tb_alu_seq_ctrl.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/alu_seq_pkg.sv
// Shared types and constants for the shift-add sequencer: state encoding,
// op codes and the bit positions of each control strobe.
package alu_seq_pkg;

    typedef enum logic [3:0] {
        IDLE, LOAD_M, LOAD_Q, ARITH, SIGN, SHIFT, OUT_A, OUT_Q, DONE
    } state_e;

    localparam logic OP_MUL = 1'b0;
    localparam logic OP_DIV = 1'b1;

    localparam int C_LOADM  = 0;
    localparam int C_LOADQ  = 1;
    localparam int C_SETQ0  = 2;
    localparam int C_ADDSUB = 3;
    localparam int C_SHIFT  = 4;
    localparam int C_OUTA   = 5;
    localparam int C_OUTQ   = 6;
    localparam int C_DONE   = 7;
    localparam int NUM_C    = 8;

    // Each state owns at most one strobe; unlisted encodings drive nothing.
    function automatic logic [NUM_C-1:0] strobe_of(input state_e s);
        logic [NUM_C-1:0] c;
        c = '0;
        case (s)
            LOAD_M:  c[C_LOADM]  = 1'b1;
            LOAD_Q:  c[C_LOADQ]  = 1'b1;
            ARITH:   c[C_ADDSUB] = 1'b1;
            SIGN:    c[C_SETQ0]  = 1'b1;
            SHIFT:   c[C_SHIFT]  = 1'b1;
            OUT_A:   c[C_OUTA]   = 1'b1;
            OUT_Q:   c[C_OUTQ]   = 1'b1;
            DONE:    c[C_DONE]   = 1'b1;
            default: c = '0;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/alu_iter_cnt.sv
// Loadable iteration down-counter; saturates at zero so it never wraps.
module alu_iter_cnt #(
    parameter int CNT_W = 5
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             dec,
    output logic             zero
);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge CLK) begin
        if (RESET)
            cnt <= '0;
        else if (load)
            cnt <= load_val;
        else if (dec && cnt != '0)
            cnt <= cnt - CNT_W'(1);
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/alu_seq_ctrl.sv
// Moore sequencer for the shift-add multiply/divide datapath. Strobes and busy
// are registered from the next state, so nothing combinational reaches them.
module alu_seq_ctrl
    import alu_seq_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH)
) (
    input  logic CLK,
    input  logic RESET,
    input  logic start,
    input  logic op,
    output logic c0,
    output logic c1,
    output logic c2,
    output logic c3,
    output logic c4,
    output logic c5,
    output logic c6,
    output logic c7,
    output logic busy,
    output logic op_q
);

    state_e           state, nxt;
    logic             cnt_zero;
    logic [NUM_C-1:0] c_q;

    alu_iter_cnt #(.CNT_W(CNT_W)) u_cnt (
        .CLK      (CLK),
        .RESET    (RESET),
        .load     (state == LOAD_Q),
        .load_val (CNT_W'(WIDTH - 1)),
        .dec      (state == SHIFT),
        .zero     (cnt_zero)
    );

    always_comb begin
        nxt = IDLE;
        case (state)
            IDLE:    nxt = start ? LOAD_M : IDLE;
            LOAD_M:  nxt = LOAD_Q;
            LOAD_Q:  nxt = ARITH;
            ARITH:   nxt = (op_q == OP_DIV) ? SIGN : SHIFT;
            SIGN:    nxt = SHIFT;
            SHIFT:   nxt = cnt_zero ? OUT_A : ARITH;
            OUT_A:   nxt = OUT_Q;
            OUT_Q:   nxt = DONE;
            DONE:    nxt = IDLE;
            default: nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state <= IDLE;
            op_q  <= OP_MUL;
            c_q   <= '0;
            busy  <= 1'b0;
        end else begin
            state <= nxt;
            c_q   <= strobe_of(nxt);
            busy  <= (nxt != IDLE);
            if (state == IDLE && start)
                op_q <= op;
        end
    end

    assign {c7, c6, c5, c4, c3, c2, c1, c0} = c_q;

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Directed bench for alu_seq_ctrl: a vector table of whole operations on a
// WIDTH=32 and a WIDTH=4 instance, plus reset, relaunch and recovery sequences.
module tb_alu_seq_ctrl;
    import alu_seq_pkg::*;

    logic CLK = 1'b0;
    logic RESET;
    logic start32, op32, start4, op4;
    logic [7:0] cv32, cv4;
    logic busy32, busy4, opq32, opq4;

    always #5 CLK = ~CLK;

    alu_seq_ctrl #(.WIDTH(32)) dut32 (
        .CLK(CLK), .RESET(RESET), .start(start32), .op(op32),
        .c0(cv32[0]), .c1(cv32[1]), .c2(cv32[2]), .c3(cv32[3]),
        .c4(cv32[4]), .c5(cv32[5]), .c6(cv32[6]), .c7(cv32[7]),
        .busy(busy32), .op_q(opq32)
    );

    alu_seq_ctrl #(.WIDTH(4)) dut4 (
        .CLK(CLK), .RESET(RESET), .start(start4), .op(op4),
        .c0(cv4[0]), .c1(cv4[1]), .c2(cv4[2]), .c3(cv4[3]),
        .c4(cv4[4]), .c5(cv4[5]), .c6(cv4[6]), .c7(cv4[7]),
        .busy(busy4), .op_q(opq4)
    );

    int total = 0;
    int passed = 0;
    int onehot_viol = 0;

    always @(negedge CLK) begin
        if ($countones(cv32) > 1 || $countones(cv4) > 1) begin
            onehot_viol++;
            $display("FAIL onehot: c32=%b c4=%b at %0t", cv32, cv4, $time);
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    typedef struct {
        string name;
        bit sm, opv, tog, pulse;
        int e_c0, e_c1, e_c5, e_c6, e_c7, e_n0, e_n2, e_n3, e_n4, e_idle;
    } vec_t;

    typedef struct {
        int t_c0, t_c1, t_c5, t_c6, t_c7, n0, n2, n3, n4, t_idle, seq_err, opq_err;
    } res_t;

    vec_t vecs[5];

    task automatic drive(input bit sm, input logic s, input logic o);
        if (sm) begin start4 = s; op4 = o; end
        else begin start32 = s; op32 = o; end
    endtask

    // Launch one operation and record strobe timing relative to the start cycle.
    task automatic run_op(input vec_t v, output res_t r);
        logic [7:0] c, ce;
        logic b, q, o;
        int w, per, ph;
        r = '{default: 0};
        w = v.sm ? 4 : 32;
        per = v.opv ? 3 : 2;
        o = v.opv;
        @(negedge CLK); drive(v.sm, 1'b1, o);
        @(negedge CLK); drive(v.sm, 1'b0, o);
        for (int k = 1; k <= 250; k++) begin
            c = v.sm ? cv4 : cv32;
            b = v.sm ? busy4 : busy32;
            q = v.sm ? opq4 : opq32;
            if (c[C_LOADM]) begin r.n0++; if (r.t_c0 == 0) r.t_c0 = k; end
            if (c[C_LOADQ] && r.t_c1 == 0) r.t_c1 = k;
            if (c[C_OUTA] && r.t_c5 == 0) r.t_c5 = k;
            if (c[C_OUTQ] && r.t_c6 == 0) r.t_c6 = k;
            if (c[C_DONE] && r.t_c7 == 0) r.t_c7 = k;
            if (c[C_SETQ0]) r.n2++;
            if (c[C_ADDSUB]) r.n3++;
            if (c[C_SHIFT]) r.n4++;
            if (k >= 3 && k < 3 + per * w) begin
                ph = (k - 3) % per;
                ce = 8'd1 << ((ph == 0) ? C_ADDSUB : (per == 3 && ph == 1) ? C_SETQ0 : C_SHIFT);
                if (c != ce) r.seq_err++;
            end
            if (b && q !== v.opv) r.opq_err++;
            if (!b) begin r.t_idle = k; break; end
            if (v.tog) o = ~o;
            drive(v.sm, v.pulse && ((k % 5 == 0 && k <= 65) || k == 69), o);
            @(negedge CLK);
        end
        drive(v.sm, 1'b0, o);
    endtask

    initial begin
        res_t r;
        int f7, s0, nsh, nstb;

        vecs[0] = '{"mul32",       0, 0, 0, 0, 1, 2, 67, 68, 69, 1, 0, 32, 32, 70};
        vecs[1] = '{"mul32_pulse", 0, 0, 0, 1, 1, 2, 67, 68, 69, 1, 0, 32, 32, 70};
        vecs[2] = '{"div32_tog",   0, 1, 1, 0, 1, 2, 99, 100, 101, 1, 32, 32, 32, 102};
        vecs[3] = '{"mul4",        1, 0, 0, 0, 1, 2, 11, 12, 13, 1, 0, 4, 4, 14};
        vecs[4] = '{"div4",        1, 1, 0, 0, 1, 2, 15, 16, 17, 1, 4, 4, 4, 18};

        RESET = 1'b1; start32 = 1'b0; op32 = 1'b0; start4 = 1'b0; op4 = 1'b0;
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        chk("rst_c32", int'(cv32), 0);
        chk("rst_busy32", int'(busy32), 0);
        chk("rst_opq32", int'(opq32), 0);
        chk("rst_c4", int'(cv4), 0);
        RESET = 1'b0;
        repeat (2) @(negedge CLK);

        foreach (vecs[i]) begin
            run_op(vecs[i], r);
            chk({vecs[i].name, "_c0"}, r.t_c0, vecs[i].e_c0);
            chk({vecs[i].name, "_c1"}, r.t_c1, vecs[i].e_c1);
            chk({vecs[i].name, "_c5"}, r.t_c5, vecs[i].e_c5);
            chk({vecs[i].name, "_c6"}, r.t_c6, vecs[i].e_c6);
            chk({vecs[i].name, "_c7"}, r.t_c7, vecs[i].e_c7);
            chk({vecs[i].name, "_n_c0"}, r.n0, vecs[i].e_n0);
            chk({vecs[i].name, "_n_c2"}, r.n2, vecs[i].e_n2);
            chk({vecs[i].name, "_n_c3"}, r.n3, vecs[i].e_n3);
            chk({vecs[i].name, "_n_c4"}, r.n4, vecs[i].e_n4);
            chk({vecs[i].name, "_idle"}, r.t_idle, vecs[i].e_idle);
            chk({vecs[i].name, "_seq_err"}, r.seq_err, 0);
            chk({vecs[i].name, "_opq_err"}, r.opq_err, 0);
            repeat (3) @(negedge CLK);
        end

        // Mid-idle reset after divides: op_q must clear.
        RESET = 1'b1;
        repeat (2) @(negedge CLK);
        chk("idle_rst_opq32", int'(opq32), 0);
        chk("idle_rst_opq4", int'(opq4), 0);
        chk("idle_rst_busy32", int'(busy32), 0);
        RESET = 1'b0;
        @(negedge CLK);

        // Start held high: relaunch after exactly one IDLE cycle.
        f7 = 0; s0 = 0;
        start32 = 1'b1; op32 = 1'b0;
        @(negedge CLK);
        for (int k = 1; k <= 160; k++) begin
            if (cv32[C_DONE] && f7 == 0) f7 = k;
            if (cv32[C_LOADM] && f7 != 0 && s0 == 0) s0 = k;
            @(negedge CLK);
        end
        start32 = 1'b0;
        chk("held_first_c7", f7, 69);
        chk("held_relaunch_gap", s0 - f7, 2);
        for (int k = 0; k < 100 && busy32; k++) @(negedge CLK);
        chk("held_drain_idle", int'(busy32), 0);
        @(negedge CLK);

        // Reset during the 10th SHIFT abandons the operation.
        nsh = 0;
        start32 = 1'b1; op32 = 1'b0;
        @(negedge CLK); start32 = 1'b0;
        for (int k = 0; k < 100; k++) begin
            if (cv32[C_SHIFT]) nsh++;
            if (nsh == 10) begin RESET = 1'b1; break; end
            @(negedge CLK);
        end
        chk("rst10_shift_seen", nsh, 10);
        @(negedge CLK);
        chk("rst10_busy", int'(busy32), 0);
        chk("rst10_c", int'(cv32), 0);
        RESET = 1'b0;
        nstb = 0;
        repeat (10) begin @(negedge CLK); if (cv32 != 8'd0 || busy32) nstb++; end
        chk("rst10_quiet", nstb, 0);

        // Illegal encoding recovers to IDLE on the next edge.
        start32 = 1'b1; op32 = 1'b1;
        @(negedge CLK); start32 = 1'b0;
        repeat (5) @(negedge CLK);
        chk("illegal_pre_busy", int'(busy32), 1);
        force dut32.state = state_e'(4'hF);
        #1;
        release dut32.state;
        @(negedge CLK);
        chk("illegal_busy", int'(busy32), 0);
        chk("illegal_c", int'(cv32), 0);
        nstb = 0;
        repeat (5) begin @(negedge CLK); if (cv32 != 8'd0 || busy32) nstb++; end
        chk("illegal_quiet", nstb, 0);

        chk("onehot_viol", onehot_viol, 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
